// File: rtl/host_mem_arbiter_if.sv
// host_mem_arbiter_if: bundle of requester-side and host-side signals for
// the host memory-channel arbiter.
//   Requester side : req_op / req_addr / req_data (flat, slice i per
//                    requester), req_done / req_rd_valid (one bit per
//                    requester), req_rd_data (broadcast read line).
//   Host side      : op_host / AddrOut_host / DataOut_host to the host
//                    controller, DataIn_host / tx_done_host / rd_valid_host
//                    back from it.
//   Status         : busy, grant_id.
// slave modport is the arbiter's view, master is the surrounding system's.
interface host_mem_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int GID_W   = 1
);
  logic [2*NUM_REQ-1:0]   req_op;
  logic [32*NUM_REQ-1:0]  req_addr;
  logic [512*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]     req_done;
  logic [NUM_REQ-1:0]     req_rd_valid;
  logic [511:0]           req_rd_data;

  logic [511:0]           DataIn_host;
  logic                   tx_done_host;
  logic                   rd_valid_host;
  logic [511:0]           DataOut_host;
  logic [31:0]            AddrOut_host;
  logic [1:0]             op_host;

  logic                   busy;
  logic [GID_W-1:0]       grant_id;

  modport slave (
    input  req_op, req_addr, req_data, DataIn_host, tx_done_host, rd_valid_host,
    output req_done, req_rd_valid, req_rd_data, DataOut_host, AddrOut_host,
           op_host, busy, grant_id
  );

  modport master (
    output req_op, req_addr, req_data, DataIn_host, tx_done_host, rd_valid_host,
    input  req_done, req_rd_valid, req_rd_data, DataOut_host, AddrOut_host,
           op_host, busy, grant_id
  );
endinterface

// File: rtl/host_mem_arbiter.sv
// host_mem_arbiter: shares one host memory-controller channel between
// NUM_REQ cache controllers. Round-robin grant of one full-line transaction
// at a time; the granted op/addr/data is registered and held on the host
// port until tx_done_host, and completion / read-valid are steered back to
// the granted requester only.
// Ports:
//   clk  - system clock, all state on rising edge
//   rst  - asynchronous active-high reset
//   bus  - host_mem_arbiter_if.slave (requester and host signals)

// Per-requester lane: request decode and response steering.
module host_mem_arbiter_lane (
  input  logic [1:0] op,
  input  logic       sel,        // this lane owns the outstanding transaction
  input  logic       tx_done,
  input  logic       rd_valid,
  output logic       requesting,
  output logic       done,
  output logic       rd_valid_out
);
  // 11 is reserved and behaves like idle, so it can never win a grant.
  assign requesting   = (op == 2'b01) || (op == 2'b10);
  assign done         = sel & tx_done;
  assign rd_valid_out = sel & rd_valid;
endmodule

module host_mem_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int GID_W   = 1
) (
  input logic            clk,
  input logic            rst,
  host_mem_arbiter_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] reqs;
  logic [NUM_REQ-1:0] sel;
  logic [GID_W-1:0]   rr_ptr;
  logic [GID_W-1:0]   grant_r;
  logic [GID_W-1:0]   winner;
  logic               any_req;
  logic               busy_o;
  logic               load;
  logic               clr_op;

  logic [1:0]         op_r;
  logic [31:0]        addr_r;
  logic [511:0]       data_r;

  logic [1:0]         win_op;
  logic [31:0]        win_addr;
  logic [511:0]       win_data;

  // Lanes
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign sel[i] = busy_o && (grant_r == GID_W'(i));
    host_mem_arbiter_lane u_lane (
      .op           (bus.req_op[2*i +: 2]),
      .sel          (sel[i]),
      .tx_done      (bus.tx_done_host),
      .rd_valid     (bus.rd_valid_host),
      .requesting   (reqs[i]),
      .done         (bus.req_done[i]),
      .rd_valid_out (bus.req_rd_valid[i])
    );
  end

  // Round-robin pick: scan rr_ptr+1, rr_ptr+2, ... with wrap; first hit wins.
  always_comb begin
    int                 idx;
    logic [NUM_REQ-1:0] sh;
    winner  = rr_ptr;
    any_req = 1'b0;
    idx     = 0;
    sh      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sh = reqs >> idx;
      if (!any_req && sh[0]) begin
        any_req = 1'b1;
        winner  = GID_W'(idx);
      end
    end
  end

  // Winner's slice, selected with constant part-selects.
  always_comb begin
    win_op   = '0;
    win_addr = '0;
    win_data = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (winner == GID_W'(j)) begin
        win_op   = bus.req_op[2*j +: 2];
        win_addr = bus.req_addr[32*j +: 32];
        win_data = bus.req_data[512*j +: 512];
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)          state_nxt = BUSY;
      BUSY:    if (bus.tx_done_host) state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  // FSM: outputs / datapath controls
  always_comb begin
    busy_o = (state == BUSY);
    load   = (state == IDLE) && any_req;
    // op_host drops to idle both on an empty IDLE cycle and on completion;
    // addr/data/grant_id are left as-is in both cases.
    clr_op = ((state == IDLE) && !any_req) ||
             ((state == BUSY) && bus.tx_done_host);
  end

  // Host-port registers, grant bookkeeping. Reset abandons any outstanding
  // transaction: busy drops, so no done is ever steered for it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r    <= 2'b00;
      addr_r  <= '0;
      data_r  <= '0;
      grant_r <= '0;
      rr_ptr  <= GID_W'(NUM_REQ-1);  // requester 0 is first in line
    end else if (load) begin
      op_r    <= win_op;
      addr_r  <= win_addr;
      data_r  <= win_data;
      grant_r <= winner;
      rr_ptr  <= winner;
    end else if (clr_op) begin
      op_r    <= 2'b00;
    end
  end

  assign bus.op_host      = op_r;
  assign bus.AddrOut_host = addr_r;
  assign bus.DataOut_host = data_r;
  assign bus.grant_id     = grant_r;
  assign bus.busy         = busy_o;
  assign bus.req_rd_data  = bus.DataIn_host;

endmodule

// File: tb/tb_host_mem_arbiter.sv
module tb_host_mem_arbiter;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  host_mem_arbiter_if #(.NUM_REQ(2), .GID_W(1)) bus ();

  host_mem_arbiter #(.NUM_REQ(2), .GID_W(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [511:0] D0  = {16{32'hD0D0_0000}};
  localparam logic [511:0] D1  = {16{32'hD1D1_1111}};
  localparam logic [511:0] RDL = {64{8'hA5}};

  typedef struct {
    logic [1:0]  op0;
    logic [1:0]  op1;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        txd;
    logic        rdv;
    logic [1:0]  e_op;
    logic [31:0] e_addr;
    logic [1:0]  e_dsel;   // 0: zero, 1: D0, 2: D1
    logic        e_busy;
    logic        e_gid;
    logic [1:0]  e_done;
    logic [1:0]  e_rdv;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] dsel(input logic [1:0] s);
    if (s == 2'd1) return D0;
    if (s == 2'd2) return D1;
    return '0;
  endfunction

  initial begin
    //           op0    op1    a0          a1        txd   rdv   e_op   e_addr      dsel  busy  gid   done   rdv
    vecs[0]  = '{2'b01, 2'b00, 32'h1000, 32'h0,    1'b0, 1'b0, 2'b00, 32'h0,    2'd0, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[1]  = '{2'b01, 2'b00, 32'h1000, 32'h0,    1'b0, 1'b1, 2'b01, 32'h1000, 2'd1, 1'b1, 1'b0, 2'b00, 2'b01};
    vecs[2]  = '{2'b01, 2'b00, 32'h1000, 32'h0,    1'b1, 1'b0, 2'b01, 32'h1000, 2'd1, 1'b1, 1'b0, 2'b01, 2'b00};
    vecs[3]  = '{2'b00, 2'b00, 32'h1000, 32'h0,    1'b1, 1'b1, 2'b00, 32'h1000, 2'd1, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[4]  = '{2'b10, 2'b10, 32'h200,  32'h300,  1'b0, 1'b0, 2'b00, 32'h1000, 2'd1, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[5]  = '{2'b10, 2'b10, 32'h200,  32'h300,  1'b1, 1'b0, 2'b10, 32'h300,  2'd2, 1'b1, 1'b1, 2'b10, 2'b00};
    vecs[6]  = '{2'b10, 2'b10, 32'h200,  32'h300,  1'b0, 1'b0, 2'b00, 32'h300,  2'd2, 1'b0, 1'b1, 2'b00, 2'b00};
    vecs[7]  = '{2'b10, 2'b10, 32'h200,  32'h300,  1'b1, 1'b0, 2'b10, 32'h200,  2'd1, 1'b1, 1'b0, 2'b01, 2'b00};
    vecs[8]  = '{2'b10, 2'b10, 32'h200,  32'h300,  1'b0, 1'b0, 2'b00, 32'h200,  2'd1, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[9]  = '{2'b10, 2'b10, 32'h200,  32'h80,   1'b0, 1'b0, 2'b10, 32'h300,  2'd2, 1'b1, 1'b1, 2'b00, 2'b00};
    vecs[10] = '{2'b00, 2'b10, 32'h200,  32'h80,   1'b1, 1'b0, 2'b10, 32'h300,  2'd2, 1'b1, 1'b1, 2'b10, 2'b00};
    vecs[11] = '{2'b11, 2'b01, 32'h200,  32'h80,   1'b0, 1'b0, 2'b00, 32'h300,  2'd2, 1'b0, 1'b1, 2'b00, 2'b00};
    vecs[12] = '{2'b11, 2'b01, 32'h200,  32'h80,   1'b1, 1'b1, 2'b01, 32'h80,   2'd2, 1'b1, 1'b1, 2'b10, 2'b10};
    vecs[13] = '{2'b11, 2'b00, 32'h200,  32'h80,   1'b0, 1'b0, 2'b00, 32'h80,   2'd2, 1'b0, 1'b1, 2'b00, 2'b00};
    vecs[14] = '{2'b11, 2'b00, 32'h200,  32'h80,   1'b0, 1'b0, 2'b00, 32'h80,   2'd2, 1'b0, 1'b1, 2'b00, 2'b00};

    rst               = 1'b1;
    bus.req_op        = '0;
    bus.req_addr      = '0;
    bus.req_data      = {D1, D0};
    bus.DataIn_host   = RDL;
    bus.tx_done_host  = 1'b0;
    bus.rd_valid_host = 1'b0;

    // Reset state
    #12;
    chk("rst.op",   512'(bus.op_host),      512'(2'b00));
    chk("rst.addr", 512'(bus.AddrOut_host), 512'(32'h0));
    chk("rst.data", bus.DataOut_host,       '0);
    chk("rst.busy", 512'(bus.busy),         512'(1'b0));
    chk("rst.gid",  512'(bus.grant_id),     512'(1'b0));
    chk("rst.done", 512'(bus.req_done),     512'(2'b00));

    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Table: drive, settle, compare, then clock
    for (int i = 0; i < 15; i++) begin
      bus.req_op        = {vecs[i].op1, vecs[i].op0};
      bus.req_addr      = {vecs[i].a1, vecs[i].a0};
      bus.tx_done_host  = vecs[i].txd;
      bus.rd_valid_host = vecs[i].rdv;
      #2;
      chk($sformatf("v%0d.op", i),    512'(bus.op_host),      512'(vecs[i].e_op));
      chk($sformatf("v%0d.addr", i),  512'(bus.AddrOut_host), 512'(vecs[i].e_addr));
      chk($sformatf("v%0d.data", i),  bus.DataOut_host,       dsel(vecs[i].e_dsel));
      chk($sformatf("v%0d.busy", i),  512'(bus.busy),         512'(vecs[i].e_busy));
      chk($sformatf("v%0d.gid", i),   512'(bus.grant_id),     512'(vecs[i].e_gid));
      chk($sformatf("v%0d.done", i),  512'(bus.req_done),     512'(vecs[i].e_done));
      chk($sformatf("v%0d.rdv", i),   512'(bus.req_rd_valid), 512'(vecs[i].e_rdv));
      chk($sformatf("v%0d.rdata", i), bus.req_rd_data,        RDL);
      @(posedge clk); #1;
    end

    // Reset in the middle of a transaction granted to requester 1
    bus.req_op        = {2'b01, 2'b00};
    bus.req_addr      = {32'h40, 32'h10};
    bus.tx_done_host  = 1'b0;
    bus.rd_valid_host = 1'b0;
    @(posedge clk); #1;
    chk("mid.busy", 512'(bus.busy),         512'(1'b1));
    chk("mid.gid",  512'(bus.grant_id),     512'(1'b1));
    chk("mid.addr", 512'(bus.AddrOut_host), 512'(32'h40));
    bus.req_op = {2'b01, 2'b01};
    #2 rst = 1'b1;
    bus.tx_done_host = 1'b1;
    #1;
    chk("arst.op",   512'(bus.op_host),      512'(2'b00));
    chk("arst.addr", 512'(bus.AddrOut_host), 512'(32'h0));
    chk("arst.data", bus.DataOut_host,       '0);
    chk("arst.busy", 512'(bus.busy),         512'(1'b0));
    chk("arst.gid",  512'(bus.grant_id),     512'(1'b0));
    chk("arst.done", 512'(bus.req_done),     512'(2'b00));
    bus.tx_done_host = 1'b0;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("post.gid",  512'(bus.grant_id),     512'(1'b0));
    chk("post.op",   512'(bus.op_host),      512'(2'b01));
    chk("post.addr", 512'(bus.AddrOut_host), 512'(32'h10));
    chk("post.data", bus.DataOut_host,       D0);
    bus.tx_done_host = 1'b1;
    #1;
    chk("post.done", 512'(bus.req_done),     512'(2'b01));
    @(posedge clk); #1;
    bus.tx_done_host = 1'b0;
    bus.req_op       = '0;
    chk("fin.op",   512'(bus.op_host), 512'(2'b00));
    chk("fin.busy", 512'(bus.busy),    512'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/host_mem_arbiter.md
Name: host_mem_arbiter

Overview:
- Shares the single host memory-controller channel between NUM_REQ cache controllers (e.g. I-cache and D-cache memory systems).
- Each requester presents a full-line host transaction (op/addr/512-bit line). The arbiter grants one requester at a time in round-robin order.
- The granted transaction is registered and held on the host port until tx_done_host. Completion and read-valid are steered back to the granted requester only.
- Sits between the per-cache mem_system host ports and the host memory controller.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- GID_W, 1, grant index width; must equal clog2(NUM_REQ), minimum 1.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_op  in  2*NUM_REQ  per-requester op. Slice i = [2i+1:2i]. Encoding: 00 idle, 01 read line, 10 write line, 11 reserved (treated as idle).
- req_addr  in  32*NUM_REQ  per-requester line address, slice i = [32i+31:32i].
- req_data  in  512*NUM_REQ  per-requester write line, slice i = [512i+511:512i].
- req_done  out  NUM_REQ  per-requester completion pulse.
- req_rd_valid  out  NUM_REQ  per-requester read-data-valid.
- req_rd_data  out  512  read line, broadcast to all requesters.
- DataIn_host  in  512  read line from host controller.
- tx_done_host  in  1  host transaction complete.
- rd_valid_host  in  1  host read data valid.
- DataOut_host  out  512  write line to host.
- AddrOut_host  out  32  address to host.
- op_host  out  2  op to host, same encoding as req_op.
- busy  out  1  transaction outstanding.
- grant_id  out  GID_W  index of current/last granted requester.

Behaviour:
- States: IDLE, BUSY.
- Reset (async, any state, including mid-transaction):
  - state=IDLE; op_host=00, AddrOut_host=0, DataOut_host=0; busy=0, grant_id=0.
  - rr_ptr=NUM_REQ-1, so requester 0 has highest priority first.
  - Any outstanding host transaction is abandoned; no req_done is issued for it.
- IDLE:
  - Requester i is requesting when req_op[i] is 01 or 10.
  - Winner = first requesting index scanning (rr_ptr+1) mod NUM_REQ upward with wrap.
  - On the edge with ≥1 requester: register op/addr/data of the winner into op_host/AddrOut_host/DataOut_host, grant_id=winner, rr_ptr=winner, busy=1, state=BUSY.
  - Latency: request sampled at edge t, op_host valid from t+1.
  - No requester: outputs unchanged except op_host=00.
- BUSY:
  - op_host, AddrOut_host, DataOut_host held constant. Requester input changes, including from the granted requester, are ignored.
  - req_rd_valid[grant_id] = rd_valid_host (combinational); all other bits 0.
  - req_rd_data = DataIn_host at all times.
  - req_done[grant_id] = tx_done_host (combinational, same cycle); all other bits 0.
  - On an edge with tx_done_host=1: state=IDLE, op_host=00, busy=0. grant_id retains its value.
- Requester obligation: hold req_op until its req_done pulse; drop or change it on the following edge. A requester that keeps req_op asserted after done is re-arbitrated as a new request.
- Back-to-back throughput: done at cycle t, IDLE at t+1, new grant registered at edge t+1→t+2. Minimum one dead cycle between host transactions.
- tx_done_host or rd_valid_host while IDLE: ignored; all req_done/req_rd_valid = 0.
- rd_valid_host and tx_done_host in the same cycle: both forwarded in that cycle.
- op 11 is never granted and never reaches op_host.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 transactions.

Test Plan:
- Reset then req_op[0]=01, addr 0x0000_1000 -> op_host=01, AddrOut_host=0x1000 one cycle later, grant_id=0, busy=1. rd_valid_host + DataIn_host=0xA5.. -> req_rd_valid=01, req_rd_data=0xA5... tx_done_host -> req_done=01 same cycle, op_host=00 next cycle.
- Both requesters write (op 10) continuously, NUM_REQ=2 -> grants alternate 0,1,0,1. Each host transaction carries the granted slice's addr/data; one idle cycle between them.
- Requester 1 changes req_addr from 0x40 to 0x80 while granted -> AddrOut_host stays 0x40 until tx_done_host.
- tx_done_host=1 and rd_valid_host=1 pulsed while IDLE -> req_done=0, req_rd_valid=0, state stays IDLE.
- rst asserted mid-BUSY (between grant and tx_done) -> outputs zero asynchronously. After release with both requesting, requester 0 granted first; no req_done for the abandoned transaction.
- req_op[0]=11 and req_op[1]=01 -> requester 1 granted, op_host=01; requester 0 never granted.
